// File: rtl/pc_sequencer.sv
// pc_sequencer: program counter, next-PC selection, ecall halt/display
// handling and saturating run-statistics counters for the single-cycle RV32 core.
module pc_sequencer #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter int unsigned CNT_W     = 32,
  parameter logic [31:0] HALT_CODE = 32'd10
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             go,
  input  logic             Beq,
  input  logic             Bne,
  input  logic             BGE,
  input  logic             JAL,
  input  logic             Jalr,
  input  logic             ecall,
  input  logic [31:0]      alu_result,
  input  logic [31:0]      rs1_data,
  input  logic [31:0]      imm,
  input  logic [31:0]      a7_data,
  input  logic [31:0]      a0_data,
  output logic [31:0]      pc,
  output logic [31:0]      pc_plus4,
  output logic             halted,
  output logic             disp_we,
  output logic [31:0]      disp_data,
  output logic [CNT_W-1:0] total_cnt,
  output logic [CNT_W-1:0] uncond_cnt,
  output logic [CNT_W-1:0] taken_cnt
);

  localparam logic [0:0] ST_RUN  = 1'b0;
  localparam logic [0:0] ST_HALT = 1'b1;

  logic [0:0]       r_state;
  logic [31:0]      r_pc;
  logic             r_halted;
  logic             r_disp_we;
  logic [31:0]      r_disp_data;
  logic [CNT_W-1:0] r_total;
  logic [CNT_W-1:0] r_uncond;
  logic [CNT_W-1:0] r_taken;

  logic [0:0]       w_next_state;
  logic [31:0]      w_next_pc;
  logic             w_disp_we;
  logic [31:0]      w_disp_data;
  logic             w_retire;
  logic             w_inc_unc;
  logic             w_inc_tak;
  logic             w_taken_br;
  logic             w_alu_zero;
  logic [31:0]      w_pc_plus4;
  logic [31:0]      w_jalr_pc;
  logic [31:0]      w_rel_pc;
  logic [31:0]      w_seq_pc;

  // Counter increment that sticks at all-ones instead of wrapping
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v, input logic en);
    logic [CNT_W-1:0] all_ones;
    all_ones = '1;
    if (en && (v != all_ones)) return v + CNT_W'(1);
    return v;
  endfunction

  // Branch resolution and candidate target addresses
  always_comb begin
    w_alu_zero = (alu_result == 32'd0);
    w_taken_br = (Beq & w_alu_zero) | (Bne & ~w_alu_zero) | (BGE & w_alu_zero);
    w_pc_plus4 = r_pc + 32'd4;
    w_jalr_pc  = (rs1_data + imm) & 32'hFFFF_FFFE;
    w_rel_pc   = r_pc + imm;
    if (Jalr)                  w_seq_pc = w_jalr_pc;
    else if (JAL || w_taken_br) w_seq_pc = w_rel_pc;
    else                       w_seq_pc = w_pc_plus4;
  end

  // Next-state, next-PC and side-effect decode
  always_comb begin
    w_next_state = r_state;
    w_next_pc    = r_pc;
    w_disp_we    = 1'b0;
    w_disp_data  = r_disp_data;
    w_retire     = 1'b0;
    w_inc_unc    = 1'b0;
    w_inc_tak    = 1'b0;
    case (r_state)
      ST_RUN: begin
        w_retire = 1'b1;
        if (ecall) begin
          // ecall overrides any other strobe; a halting ecall keeps pc on itself
          if (a7_data == HALT_CODE) begin
            w_next_state = ST_HALT;
          end else begin
            w_disp_we   = 1'b1;
            w_disp_data = a0_data;
            w_next_pc   = w_pc_plus4;
          end
        end else begin
          w_next_pc = w_seq_pc;
          w_inc_unc = JAL | Jalr;
          w_inc_tak = w_taken_br;
        end
      end
      ST_HALT: begin
        if (go) begin
          w_next_state = ST_RUN;
          w_next_pc    = w_pc_plus4;
        end
      end
      default: w_next_state = ST_RUN;
    endcase
  end

  // State, PC, display and counter registers
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= ST_RUN;
      r_pc        <= RESET_PC;
      r_halted    <= 1'b0;
      r_disp_we   <= 1'b0;
      r_disp_data <= 32'd0;
      r_total     <= '0;
      r_uncond    <= '0;
      r_taken     <= '0;
    end else begin
      r_state     <= w_next_state;
      r_pc        <= w_next_pc;
      r_halted    <= (w_next_state == ST_HALT);
      r_disp_we   <= w_disp_we;
      r_disp_data <= w_disp_data;
      r_total     <= sat_inc(r_total, w_retire);
      r_uncond    <= sat_inc(r_uncond, w_inc_unc);
      r_taken     <= sat_inc(r_taken, w_inc_tak);
    end
  end

  assign pc         = r_pc;
  assign pc_plus4   = w_pc_plus4;
  assign halted     = r_halted;
  assign disp_we    = r_disp_we;
  assign disp_data  = r_disp_data;
  assign total_cnt  = r_total;
  assign uncond_cnt = r_uncond;
  assign taken_cnt  = r_taken;

endmodule

// File: tb/tb_pc_sequencer.sv
// tb_pc_sequencer: vector table + scoreboard bench for pc_sequencer,
// with a second narrow-counter instance for saturation.
module tb_pc_sequencer;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, go, Beq, Bne, BGE, JAL, Jalr, ecall;
  logic [31:0] alu_result, rs1_data, imm, a7_data, a0_data;

  logic [31:0] pc, pc_plus4, disp_data, total_cnt, uncond_cnt, taken_cnt;
  logic        halted, disp_we;

  logic [31:0] pc4, pc_plus4_4, disp_data4;
  logic        halted4, disp_we4;
  logic [3:0]  tot4, unc4, tak4;

  pc_sequencer #(.RESET_PC(32'h0), .CNT_W(32), .HALT_CODE(32'd10)) dut (
    .clk(clk), .rst(rst), .go(go), .Beq(Beq), .Bne(Bne), .BGE(BGE), .JAL(JAL),
    .Jalr(Jalr), .ecall(ecall), .alu_result(alu_result), .rs1_data(rs1_data),
    .imm(imm), .a7_data(a7_data), .a0_data(a0_data), .pc(pc), .pc_plus4(pc_plus4),
    .halted(halted), .disp_we(disp_we), .disp_data(disp_data),
    .total_cnt(total_cnt), .uncond_cnt(uncond_cnt), .taken_cnt(taken_cnt)
  );

  pc_sequencer #(.RESET_PC(32'h0), .CNT_W(4), .HALT_CODE(32'd10)) dut4 (
    .clk(clk), .rst(rst), .go(go), .Beq(Beq), .Bne(Bne), .BGE(BGE), .JAL(JAL),
    .Jalr(Jalr), .ecall(ecall), .alu_result(alu_result), .rs1_data(rs1_data),
    .imm(imm), .a7_data(a7_data), .a0_data(a0_data), .pc(pc4), .pc_plus4(pc_plus4_4),
    .halted(halted4), .disp_we(disp_we4), .disp_data(disp_data4),
    .total_cnt(tot4), .uncond_cnt(unc4), .taken_cnt(tak4)
  );

  typedef struct {
    logic        rst, go, beq, bne, bge, jal, jalr, ecall;
    logic [31:0] alu, rs1, imm, a7, a0;
    logic [31:0] e_pc;
    logic        e_h, e_we;
    logic [31:0] e_dd, e_t, e_u, e_k;
  } vec_t;

  localparam logic [7:0] S_N    = 8'h00;
  localparam logic [7:0] S_RST  = 8'h80;
  localparam logic [7:0] S_GO   = 8'h40;
  localparam logic [7:0] S_BEQ  = 8'h20;
  localparam logic [7:0] S_BNE  = 8'h10;
  localparam logic [7:0] S_BGE  = 8'h08;
  localparam logic [7:0] S_JAL  = 8'h04;
  localparam logic [7:0] S_JALR = 8'h02;
  localparam logic [7:0] S_ECL  = 8'h01;

  vec_t       vecs[$];
  vec_t       exp_q[$];
  logic [3:0] sat_q[$];
  int         n_pass = 0;
  int         n_total = 0;

  function automatic vec_t mk(input logic [7:0] s,
                              input logic [31:0] alu, rs1, im, a7, a0, e_pc,
                              input logic e_h, e_we,
                              input logic [31:0] e_dd, e_t, e_u, e_k);
    vec_t v;
    v.rst = s[7]; v.go = s[6]; v.beq = s[5]; v.bne = s[4];
    v.bge = s[3]; v.jal = s[2]; v.jalr = s[1]; v.ecall = s[0];
    v.alu = alu; v.rs1 = rs1; v.imm = im; v.a7 = a7; v.a0 = a0;
    v.e_pc = e_pc; v.e_h = e_h; v.e_we = e_we;
    v.e_dd = e_dd; v.e_t = e_t; v.e_u = e_u; v.e_k = e_k;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  // Drive one vector, record its expectation, then compare after the edge
  task automatic step(input string tag, input vec_t v);
    vec_t e;
    @(negedge clk);
    rst = v.rst; go = v.go; Beq = v.beq; Bne = v.bne; BGE = v.bge;
    JAL = v.jal; Jalr = v.jalr; ecall = v.ecall;
    alu_result = v.alu; rs1_data = v.rs1; imm = v.imm; a7_data = v.a7; a0_data = v.a0;
    exp_q.push_back(v);
    @(posedge clk);
    #1;
    e = exp_q.pop_front();
    chk({tag, " pc"},        pc,         e.e_pc);
    chk({tag, " pc_plus4"},  pc_plus4,   e.e_pc + 32'd4);
    chk({tag, " halted"},    {31'd0, halted},  {31'd0, e.e_h});
    chk({tag, " disp_we"},   {31'd0, disp_we}, {31'd0, e.e_we});
    chk({tag, " disp_data"}, disp_data,  e.e_dd);
    chk({tag, " total_cnt"}, total_cnt,  e.e_t);
    chk({tag, " uncond_cnt"}, uncond_cnt, e.e_u);
    chk({tag, " taken_cnt"}, taken_cnt,  e.e_k);
  endtask

  initial begin
    vec_t        v;
    logic [31:0] db;
    db = 32'hDEAD_BEEF;
    rst = 1'b1; go = 1'b0; Beq = 1'b0; Bne = 1'b0; BGE = 1'b0;
    JAL = 1'b0; Jalr = 1'b0; ecall = 1'b0;
    alu_result = '0; rs1_data = '0; imm = '0; a7_data = '0; a0_data = '0;

    //            strobes        alu  rs1       imm            a7  a0           pc          h  we dd  tot unc tak
    vecs.push_back(mk(S_RST,        0, 0,        0,             0,  0,           32'h0,      0, 0, 0,  0,  0,  0)); // 0
    vecs.push_back(mk(S_N,          0, 0,        0,             0,  0,           32'h4,      0, 0, 0,  1,  0,  0));
    vecs.push_back(mk(S_N,          0, 0,        0,             0,  0,           32'h8,      0, 0, 0,  2,  0,  0));
    vecs.push_back(mk(S_N,          0, 0,        0,             0,  0,           32'hC,      0, 0, 0,  3,  0,  0));
    vecs.push_back(mk(S_N,          0, 0,        0,             0,  0,           32'h10,     0, 0, 0,  4,  0,  0));
    vecs.push_back(mk(S_BEQ,        0, 0,        32'hFFFF_FFF8, 0,  0,           32'h8,      0, 0, 0,  5,  0,  1)); // 5
    vecs.push_back(mk(S_BNE,        0, 0,        32'hFFFF_FFF8, 0,  0,           32'hC,      0, 0, 0,  6,  0,  1));
    vecs.push_back(mk(S_BNE,        5, 0,        32'h10,        0,  0,           32'h1C,     0, 0, 0,  7,  0,  2));
    vecs.push_back(mk(S_BGE,        1, 0,        32'h100,       0,  0,           32'h20,     0, 0, 0,  8,  0,  2));
    vecs.push_back(mk(S_BGE,        0, 0,        32'h20,        0,  0,           32'h40,     0, 0, 0,  9,  0,  3));
    vecs.push_back(mk(S_JALR,       0, 32'h101,  32'h2,         0,  0,           32'h102,    0, 0, 0, 10,  1,  3)); // 10
    vecs.push_back(mk(S_JAL,        0, 0,        32'h10,        0,  0,           32'h112,    0, 0, 0, 11,  2,  3));
    vecs.push_back(mk(S_JAL|S_JALR, 0, 32'h1F1,  32'h10,        0,  0,           32'h200,    0, 0, 0, 12,  3,  3));
    vecs.push_back(mk(S_BEQ|S_JAL,  0, 0,        32'h8,         0,  0,           32'h208,    0, 0, 0, 13,  4,  4));
    vecs.push_back(mk(S_ECL,        0, 0,        0,             1,  db,          32'h20C,    0, 1, db, 14,  4,  4));
    vecs.push_back(mk(S_GO,         0, 0,        0,             0,  0,           32'h210,    0, 0, db, 15,  4,  4)); // 15
    vecs.push_back(mk(S_JAL,        0, 0,        32'hFFFF_FE30, 0,  0,           32'h40,     0, 0, db, 16,  5,  4));
    vecs.push_back(mk(S_ECL,        0, 0,        0,             10, 32'h1234,    32'h40,     1, 0, db, 17,  5,  4));
    vecs.push_back(mk(S_GO,         0, 0,        0,             0,  0,           32'h44,     0, 0, db, 17,  5,  4)); // 18
    vecs.push_back(mk(S_N,          0, 0,        0,             0,  0,           32'h48,     0, 0, db, 18,  5,  4));
    vecs.push_back(mk(S_ECL,        0, 0,        0,             10, 0,           32'h48,     1, 0, db, 19,  5,  4)); // 20
    vecs.push_back(mk(S_RST|S_GO|S_JAL|S_ECL, 0, 0, 32'h100,    10, 32'h55,      32'h0,      0, 0, 0,  0,  0,  0));
    vecs.push_back(mk(S_JAL,        0, 0,        32'hFFFF_FFFC, 0,  0,           32'hFFFF_FFFC, 0, 0, 0, 1, 1,  0));
    vecs.push_back(mk(S_N,          0, 0,        0,             0,  0,           32'h0,      0, 0, 0,  2,  1,  0));
    vecs.push_back(mk(S_BEQ,        7, 0,        32'h40,        0,  0,           32'h4,      0, 0, 0,  3,  1,  0));

    for (int i = 0; i < vecs.size(); i++) begin
      if (i == 18) begin
        // Halted: random strobes and ecalls must leave everything frozen
        for (int k = 0; k < 5; k++) begin
          v = mk({2'b00, 6'($urandom)}, $urandom, $urandom, $urandom, $urandom, $urandom,
                 32'h40, 1, 0, db, 17, 5, 4);
          step($sformatf("halt%0d", k), v);
        end
      end
      step($sformatf("v%0d", i), vecs[i]);
    end

    // Narrow counters: 20 JALs after reset saturate at 15
    step("sat_rst", mk(S_RST, 0, 0, 0, 0, 0, 32'h0, 0, 0, 0, 0, 0, 0));
    chk("sat_rst unc4", {28'd0, unc4}, 32'd0);
    for (int n = 1; n <= 20; n++) begin
      sat_q.push_back((n > 15) ? 4'd15 : 4'(n));
      step($sformatf("sat%0d", n),
           mk(S_JAL, 0, 0, 32'h4, 0, 0, 32'(4 * n), 0, 0, 0, 32'(n), 32'(n), 0));
      begin
        logic [3:0] es;
        es = sat_q.pop_front();
        chk($sformatf("sat%0d unc4", n), {28'd0, unc4}, {28'd0, es});
        chk($sformatf("sat%0d tot4", n), {28'd0, tot4}, {28'd0, es});
        chk($sformatf("sat%0d tak4", n), {28'd0, tak4}, 32'd0);
      end
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
